mux2x1_rr_arbiter: RTL and testbench

Sequencing controller that shares one 2:1 data mux between two packet requesters and one downstream consumer. It runs round-robin arbitration, holds the mux select for a whole packet (lock until the last beat is accepted), and drives a valid/ready handshake toward the consumer. A beat counter forces release of a runaway packet. Sits directly in front of the gate-level mux datapath as the block that owns its select line.

---
 rtl/mux2x1_rr_arbiter_pkg.sv | 15 +
 rtl/mux2x1_rr_arbiter_if.sv | 30 +++
 rtl/mux2x1_rr_arbiter_bus.sv | 15 +
 rtl/mux2x1_rr_arbiter.sv | 107 ++++++++++
 tb/tb_mux2x1_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux2x1_rr_arbiter_pkg.sv
// Shared types for the round-robin 2:1 mux arbiter: FSM state encodings and helpers.
package mux2x1_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    // Ownership state for requester n.
    function automatic state_e own_state(input logic n);
        return n ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mux2x1_rr_arbiter_if.sv
// Requester/consumer bundle for the arbiter; slave is the arbiter side, master the environment.
interface mux2x1_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             last0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             last1;
    logic             gnt1;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic             busy;
    logic             err;

    modport slave (
        input  req0, data0, last0, req1, data1, last1, out_ready,
        output gnt0, gnt1, out_valid, out_data, out_last, sel, busy, err
    );

    modport master (
        output req0, data0, last0, req1, data1, last1, out_ready,
        input  gnt0, gnt1, out_valid, out_data, out_last, sel, busy, err
    );
endinterface

// File: rtl/mux2x1_rr_arbiter_bus.sv
// W-bit 2:1 mux assembled from one mux2x1 cell per bit; sel_i = 1 selects b_i.
module mux2x1_rr_arbiter_bus #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);

    for (genvar i = 0; i < W; i++) begin : g_mux2x1
        assign y_o[i] = sel_i ? b_i[i] : a_i[i];
    end

endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin owner of a shared 2:1 packet mux: locks select per packet, forces release at MAX_BEATS.
module mux2x1_rr_arbiter
    import mux2x1_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mux2x1_rr_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;

    logic             own_c;
    logic             cur_c;
    logic             req_cur_c;
    logic             req_oth_c;
    logic             accept_c;
    logic             err_c;
    logic [WIDTH:0]   mux_y;

    mux2x1_rr_arbiter_bus #(.W(WIDTH + 1)) u_bus (
        .a_i   ({bus.last0, bus.data0}),
        .b_i   ({bus.last1, bus.data1}),
        .sel_i (sel_q),
        .y_o   (mux_y)
    );

    assign own_c     = (state_q == OWN0) || (state_q == OWN1);
    assign cur_c     = (state_q == OWN1);
    assign req_cur_c = cur_c ? bus.req1 : bus.req0;
    assign req_oth_c = cur_c ? bus.req0 : bus.req1;
    assign accept_c  = own_c && req_cur_c && bus.out_ready;

    // Next-state: arbitration in IDLE, packet lock and release in OWNn.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 && (!bus.req1 || !prio_q)) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (accept_c) begin
                    if (mux_y[WIDTH] || (cnt_q == CNT_W'(MAX_BEATS - 1))) begin
                        err_c   = !mux_y[WIDTH];
                        prio_d  = !cur_c;
                        cnt_d   = '0;
                        if (req_oth_c) begin
                            state_d = own_state(!cur_c);
                        end else if (req_cur_c) begin
                            state_d = own_state(cur_c);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            OWN0:    sel_d = 1'b0;
            OWN1:    sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Data path outputs are forced to zero whenever nobody owns the mux.
    assign bus.gnt0      = (state_q == OWN0);
    assign bus.gnt1      = (state_q == OWN1);
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = own_c && req_cur_c;
    assign bus.out_data  = own_c ? mux_y[WIDTH-1:0] : '0;
    assign bus.out_last  = own_c && mux_y[WIDTH];
    assign bus.err       = err_c;

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Scoreboard bench for mux2x1_rr_arbiter: directed packets, expected beats queued in acceptance order.
module tb_mux2x1_rr_arbiter;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_BEATS = 16;

    typedef struct packed {
        logic             src;
        logic [WIDTH-1:0] data;
        logic             last;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [WIDTH:0] q0[$];
    logic [WIDTH:0] q1[$];
    exp_t           sb[$];
    logic           pause0 = 1'b0;
    logic           rdy    = 1'b0;

    mux2x1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux2x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        if (q0.size() > 0) {bus.last0, bus.data0} = q0[0];
        else               {bus.last0, bus.data0} = '0;
        if (q1.size() > 0) {bus.last1, bus.data1} = q1[0];
        else               {bus.last1, bus.data1} = '0;
        bus.req0      = (q0.size() > 0) && !pause0 && !rst;
        bus.req1      = (q1.size() > 0) && !rst;
        bus.out_ready = rdy;
    endtask

    // Requester model: sample handshakes mid-cycle, retire beats after the edge.
    task automatic tick();
        logic a0, a1;
        @(negedge clk);
        a0 = bus.req0 & bus.gnt0 & bus.out_ready;
        a1 = bus.req1 & bus.gnt1 & bus.out_ready;
        @(posedge clk);
        #1;
        if (a0 && q0.size() > 0) void'(q0.pop_front());
        if (a1 && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic exp_beat(input logic src, input logic [WIDTH-1:0] d, input logic l, input logic e);
        exp_t x;
        x.src = src; x.data = d; x.last = l; x.err = e;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete(); q1.delete(); sb.delete();
        pause0 = 1'b0;
        rdy    = 1'b0;
        drive();
        tick();
        rst = 1'b0;
        drive();
        tick();
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("gnt_mutex", 32'(bus.gnt0 & bus.gnt1), 32'(0));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h with nothing expected at %0t", bus.out_data, $time);
                end else begin
                    e = sb.pop_front();
                    check("beat_src",  32'(bus.gnt1),     32'(e.src));
                    check("beat_data", 32'(bus.out_data), 32'(e.data));
                    check("beat_last", 32'(bus.out_last), 32'(e.last));
                    check("beat_err",  32'(bus.err),      32'(e.err));
                end
            end else begin
                check("err_no_beat", 32'(bus.err), 32'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive();
        tick();
        tick();
        check("rst_gnt0",      32'(bus.gnt0),      32'(0));
        check("rst_gnt1",      32'(bus.gnt1),      32'(0));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_busy",      32'(bus.busy),      32'(0));
        check("rst_sel",       32'(bus.sel),       32'(0));
        rst = 1'b0;
        drive();
        tick();
        tick();
        check("idle_busy", 32'(bus.busy), 32'(0));
        check("idle_gnt0", 32'(bus.gnt0), 32'(0));

        // Single requester, three beats.
        rdy = 1'b1;
        q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
        exp_beat(1'b0, 8'hA1, 1'b0, 1'b0);
        exp_beat(1'b0, 8'hA2, 1'b0, 1'b0);
        exp_beat(1'b0, 8'hA3, 1'b1, 1'b0);
        drive();
        check("single_no_gnt_yet", 32'(bus.gnt0), 32'(0));
        tick();
        check("single_gnt0", 32'(bus.gnt0),     32'(1));
        check("single_data", 32'(bus.out_data), 32'(8'hA1));
        repeat (3) tick();
        check("single_drained", 32'(sb.size()), 32'(0));

        // Contention: alternating grants with no bubble.
        do_reset();
        rdy = 1'b1;
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b1, 8'h02});
        q0.push_back({1'b0, 8'h05}); q0.push_back({1'b1, 8'h06});
        q1.push_back({1'b0, 8'h03}); q1.push_back({1'b1, 8'h04});
        q1.push_back({1'b0, 8'h07}); q1.push_back({1'b1, 8'h08});
        exp_beat(1'b0, 8'h01, 1'b0, 1'b0); exp_beat(1'b0, 8'h02, 1'b1, 1'b0);
        exp_beat(1'b1, 8'h03, 1'b0, 1'b0); exp_beat(1'b1, 8'h04, 1'b1, 1'b0);
        exp_beat(1'b0, 8'h05, 1'b0, 1'b0); exp_beat(1'b0, 8'h06, 1'b1, 1'b0);
        exp_beat(1'b1, 8'h07, 1'b0, 1'b0); exp_beat(1'b1, 8'h08, 1'b1, 1'b0);
        drive();
        tick();
        check("rr_first_gnt0", 32'(bus.gnt0), 32'(1));
        repeat (8) tick();
        check("rr_no_bubble", 32'(sb.size()), 32'(0));

        // Backpressure on requester 1.
        do_reset();
        q1.push_back({1'b0, 8'hB1}); q1.push_back({1'b1, 8'hB2});
        exp_beat(1'b1, 8'hB1, 1'b0, 1'b0);
        exp_beat(1'b1, 8'hB2, 1'b1, 1'b0);
        drive();
        tick();
        check("bp_gnt1", 32'(bus.gnt1), 32'(1));
        check("bp_sel",  32'(bus.sel),  32'(1));
        repeat (4) begin
            tick();
            check("bp_hold_data",  32'(bus.out_data),  32'(8'hB1));
            check("bp_hold_gnt1",  32'(bus.gnt1),      32'(1));
            check("bp_hold_valid", 32'(bus.out_valid), 32'(1));
        end
        rdy = 1'b1;
        drive();
        tick();
        tick();
        check("bp_drained", 32'(sb.size()), 32'(0));

        // Requester 0 gap while requester 1 waits.
        do_reset();
        rdy = 1'b1;
        q0.push_back({1'b0, 8'hC1}); q0.push_back({1'b0, 8'hC2}); q0.push_back({1'b1, 8'hC3});
        q1.push_back({1'b0, 8'hD1}); q1.push_back({1'b1, 8'hD2});
        exp_beat(1'b0, 8'hC1, 1'b0, 1'b0); exp_beat(1'b0, 8'hC2, 1'b0, 1'b0);
        exp_beat(1'b0, 8'hC3, 1'b1, 1'b0);
        exp_beat(1'b1, 8'hD1, 1'b0, 1'b0); exp_beat(1'b1, 8'hD2, 1'b1, 1'b0);
        drive();
        tick();
        check("gap_gnt0", 32'(bus.gnt0), 32'(1));
        tick();
        pause0 = 1'b1;
        drive();
        repeat (3) begin
            tick();
            check("gap_valid_low", 32'(bus.out_valid), 32'(0));
            check("gap_gnt0_held", 32'(bus.gnt0),      32'(1));
            check("gap_gnt1_low",  32'(bus.gnt1),      32'(0));
        end
        pause0 = 1'b0;
        drive();
        tick();
        tick();
        check("gap_handoff_gnt1", 32'(bus.gnt1), 32'(1));
        tick();
        tick();
        check("gap_drained", 32'(sb.size()), 32'(0));

        // Forced release after MAX_BEATS beats without last.
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < int'(MAX_BEATS); i++) begin
            q0.push_back({1'b0, 8'(8'h40 + i)});
            exp_beat(1'b0, 8'(8'h40 + i), 1'b0, i == int'(MAX_BEATS) - 1);
        end
        q1.push_back({1'b1, 8'hE1});
        exp_beat(1'b1, 8'hE1, 1'b1, 1'b0);
        drive();
        tick();
        check("force_gnt0", 32'(bus.gnt0), 32'(1));
        repeat (MAX_BEATS - 1) tick();
        check("force_err_pulse", 32'(bus.err), 32'(1));
        tick();
        check("force_gnt1_next", 32'(bus.gnt1), 32'(1));
        check("force_err_cleared", 32'(bus.err), 32'(0));
        tick();
        check("force_drained", 32'(sb.size()), 32'(0));

        // Reset asserted mid-packet.
        do_reset();
        q1.push_back({1'b0, 8'hF1}); q1.push_back({1'b1, 8'hF2});
        drive();
        tick();
        check("mid_pre_sel",   32'(bus.sel),       32'(1));
        check("mid_pre_valid", 32'(bus.out_valid), 32'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_gnt1",  32'(bus.gnt1),      32'(0));
        check("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        check("mid_rst_data",  32'(bus.out_data),  32'(0));
        check("mid_rst_last",  32'(bus.out_last),  32'(0));
        check("mid_rst_sel",   32'(bus.sel),       32'(0));
        check("mid_rst_busy",  32'(bus.busy),      32'(0));
        check("mid_rst_err",   32'(bus.err),       32'(0));
        q1.delete();
        drive();
        tick();
        rst = 1'b0;
        drive();
        tick();
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'(0));
        check("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
